// File: rtl/spi_load_sequencer_pkg.sv
// Shared definitions for the SPI load sequencer: opcodes, FSM states and
// header field positions.
package spi_load_sequencer_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_HALT  = 8'h03;
  localparam logic [7:0] OP_CLR   = 8'h04;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int LEN_MSB  = 23;
  localparam int LEN_LSB  = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

endpackage

// File: rtl/spi_load_sequencer_checksum.sv
// XOR accumulator over a load packet; clr+acc together seeds it with the
// header word, acc alone folds in a data word, match compares a trailer.
module spi_load_checksum #(
  parameter int W = 32
) (
  input  logic         w_SPI_Clk,
  input  logic         i_rst_n,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] word,
  output logic         match
);

  logic [W-1:0] sum;

  always_ff @(posedge w_SPI_Clk or negedge i_rst_n) begin
    if (!i_rst_n)       sum <= '0;
    else if (clr && acc) sum <= word;
    else if (clr)        sum <= '0;
    else if (acc)        sum <= sum ^ word;
  end

  assign match = (sum == word);

endmodule

// File: rtl/spi_load_sequencer.sv
// Parses the SPI word stream into load commands and owns memory ownership.
// Optional checksum trailer: define SPI_LOAD_CHECKSUM_EN.
module spi_load_sequencer
  import spi_load_sequencer_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                      w_SPI_Clk,
  input  logic                      i_rst_n,
  input  logic                      i_cs_n,
  input  logic                      i_word_vld,
  input  logic [DATA_LENGTH-1:0]    i_word,
  output logic                      o_wr_en,
  output logic [ADDRESS_LENGTH-1:0] o_wr_addr,
  output logic [DATA_LENGTH-1:0]    o_wr_data,
  output logic                      o_core_select,
  output logic                      o_busy,
  output logic                      o_err
);

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic [15:0] addr;
  logic        accept, hdr_go, data_word, last;
  logic [7:0]  op;

  assign accept    = i_word_vld & ~i_cs_n;
  assign op        = i_word[OP_MSB:OP_LSB];
  assign hdr_go    = (state == ST_IDLE) && accept && (op == OP_WRITE) && !o_core_select;
  assign data_word = (state == ST_DATA) && accept;
  assign last      = data_word && (cnt == 8'd0);
  assign o_busy    = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (hdr_go) next_state = ST_DATA;
`ifdef SPI_LOAD_CHECKSUM_EN
      ST_DATA: if (last) next_state = ST_CSUM;
      ST_CSUM: if (accept) next_state = ST_IDLE;
`else
      ST_DATA: if (last) next_state = ST_IDLE;
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Deselect drops any packet in flight without touching ownership or errors.
  always_ff @(posedge w_SPI_Clk or negedge i_rst_n or posedge i_cs_n) begin
    if (!i_rst_n)     state <= ST_IDLE;
    else if (i_cs_n)  state <= ST_IDLE;
    else              state <= next_state;
  end

  always_ff @(posedge w_SPI_Clk or negedge i_rst_n or posedge i_cs_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      addr <= '0;
    end else if (i_cs_n) begin
      cnt  <= '0;
      addr <= '0;
    end else if (hdr_go) begin
      cnt  <= i_word[LEN_MSB:LEN_LSB];
      addr <= i_word[ADDR_MSB:ADDR_LSB];
    end else if (data_word) begin
      addr <= addr + 16'd1;
      if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end
  end

`ifdef SPI_LOAD_CHECKSUM_EN
  logic csum_match;

  spi_load_checksum #(.W(DATA_LENGTH)) u_csum (
    .w_SPI_Clk (w_SPI_Clk),
    .i_rst_n   (i_rst_n),
    .clr       (hdr_go),
    .acc       (hdr_go | data_word),
    .word      (i_word),
    .match     (csum_match)
  );
`endif

  always_ff @(posedge w_SPI_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_core_select <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_wr_en <= data_word;
      if (data_word) begin
        o_wr_addr <= ADDRESS_LENGTH'(addr);
        o_wr_data <= i_word;
      end
      if ((state == ST_IDLE) && accept) begin
        case (op)
          OP_WRITE: if (o_core_select) o_err <= 1'b1;
          OP_RUN:   if (!o_err) o_core_select <= 1'b1;
          OP_HALT:  o_core_select <= 1'b0;
          OP_CLR:   o_err <= 1'b0;
          default:  o_err <= 1'b1;
        endcase
      end
`ifdef SPI_LOAD_CHECKSUM_EN
      if ((state == ST_CSUM) && accept && !csum_match) o_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_spi_load_sequencer.sv
// Directed + randomized bench for spi_load_sequencer against a packet-level
// reference model; follows SPI_LOAD_CHECKSUM_EN when defined.
module tb_spi_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, vld;
  logic [31:0] word;
  logic        wr_en, core_select, busy, err;
  logic [31:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  // Reference model: packet-level view of the load protocol
  int          m_rem;
  bit          m_csum_pend, m_core, m_err, m_busy, m_wen;
  logic [15:0] m_addr;
  logic [31:0] m_xsum, m_waddr, m_wdata;

  spi_load_sequencer #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) dut (
    .w_SPI_Clk     (clk),
    .i_rst_n       (rst_n),
    .i_cs_n        (cs_n),
    .i_word_vld    (vld),
    .i_word        (word),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_core_select (core_select),
    .o_busy        (busy),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wr_en"},   {31'd0, wr_en},       {31'd0, m_wen});
    check({tag, ".wr_addr"}, wr_addr,              m_waddr);
    check({tag, ".wr_data"}, wr_data,              m_wdata);
    check({tag, ".busy"},    {31'd0, busy},        {31'd0, m_busy});
    check({tag, ".core"},    {31'd0, core_select}, {31'd0, m_core});
    check({tag, ".err"},     {31'd0, err},         {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_rem = 0; m_csum_pend = 0; m_core = 0; m_err = 0; m_busy = 0; m_wen = 0;
    m_addr = '0; m_xsum = '0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_step(input logic [31:0] w);
    m_wen = 0;
    if (m_rem > 0) begin
      m_wen = 1; m_waddr = {16'd0, m_addr}; m_wdata = w;
      m_addr = m_addr + 16'd1;
      m_xsum ^= w;
      m_rem--;
      if (m_rem == 0) begin
`ifdef SPI_LOAD_CHECKSUM_EN
        m_csum_pend = 1;
`else
        m_busy = 0;
`endif
      end
    end else if (m_csum_pend) begin
      if (w != m_xsum) m_err = 1;
      m_csum_pend = 0; m_busy = 0;
    end else begin
      case (w[31:24])
        8'h01: if (m_core) m_err = 1;
               else begin
                 m_rem = int'(w[23:16]) + 1; m_addr = w[15:0]; m_xsum = w; m_busy = 1;
               end
        8'h02: if (!m_err) m_core = 1;
        8'h03: m_core = 0;
        8'h04: m_err = 0;
        default: m_err = 1;
      endcase
    end
  endtask

  // One word pulse, checked one edge later, then 'gap' idle cycles
  task automatic send(input logic [31:0] w, input int gap);
    @(negedge clk); vld = 1; word = w;
    model_step(w);
    @(posedge clk); #1; vld = 0;
    check_all("word");
    m_wen = 0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      check_all("gap");
    end
  endtask

  task automatic send_write(input logic [15:0] base, input logic [7:0] len, input bit corrupt);
    logic [31:0] hdr, d, x;
    hdr = {8'h01, len, base};
    x = hdr;
    send(hdr, $urandom_range(0, 2));
    for (int i = 0; i <= int'(len); i++) begin
      d = $urandom;
      x ^= d;
      send(d, $urandom_range(0, 2));
    end
    x = corrupt ? (x ^ 32'h0000_0100) : x;
`ifdef SPI_LOAD_CHECKSUM_EN
    send(x, 1);
`endif
  endtask

  task automatic cmd(input logic [7:0] op);
    send({op, 24'($urandom)}, 1);
  endtask

  task automatic abort_seq(input bit with_vld);
    @(negedge clk); cs_n = 1; vld = with_vld; word = $urandom;
    m_rem = 0; m_csum_pend = 0; m_busy = 0; m_wen = 0;
    #1; check("abort_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1; vld = 0;
    check_all("abort_edge");
    @(negedge clk); vld = 1; word = $urandom;
    @(posedge clk); #1; vld = 0;
    check_all("cs_high_vld");
    @(negedge clk); cs_n = 0;
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 0; cs_n = 0; vld = 0; word = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1; check_all("reset");
    @(negedge clk); rst_n = 1;

    // Basic burst and 16-bit address wrap
    send_write(16'h0010, 8'd3, 0);
    check("busy_after_burst", {31'd0, busy}, 32'd0);
    send_write(16'hFFFE, 8'd2, 0);
    check("wrap_last_addr", wr_addr, 32'h0000_0000);

    // Randomized bursts, including a full 256-word burst
    for (int p = 0; p < 12; p++)
      send_write(16'($urandom), 8'($urandom_range(0, 12)), 0);
    send_write(16'($urandom), 8'd255, 0);

    // Ownership: WRITE rejected while the core owns memory
    cmd(8'h02);
    check("run_core", {31'd0, core_select}, 32'd1);
    send({8'h01, 8'd3, 16'h0200}, 1);
    check("write_rejected_err", {31'd0, err}, 32'd1);
    cmd(8'h03);
    cmd(8'h04);
    check("halt_clr_core", {31'd0, core_select}, 32'd0);
    check("halt_clr_err", {31'd0, err}, 32'd0);

    // Deselect mid-burst after 3 of 8 words, then a fresh packet
    send({8'h01, 8'd7, 16'h0300}, 1);
    for (int i = 0; i < 3; i++) send($urandom, 0);
    abort_seq(0);
    send_write(16'h0400, 8'd1, 0);

    // Deselect coinciding with a data word
    send({8'h01, 8'd4, 16'h0500}, 0);
    send($urandom, 0);
    abort_seq(1);

    // Illegal opcode blocks RUN until CLR
    cmd(8'h55);
    check("bad_op_err", {31'd0, err}, 32'd1);
    cmd(8'h02);
    check("run_blocked", {31'd0, core_select}, 32'd0);
    cmd(8'h04);
    cmd(8'h02);
    check("run_after_clr", {31'd0, core_select}, 32'd1);
    cmd(8'h03);

`ifdef SPI_LOAD_CHECKSUM_EN
    send_write(16'h0600, 8'd5, 0);
    check("csum_ok_err", {31'd0, err}, 32'd0);
    cmd(8'h02);
    check("csum_ok_run", {31'd0, core_select}, 32'd1);
    cmd(8'h03);
    send_write(16'h0700, 8'd5, 1);
    check("csum_bad_err", {31'd0, err}, 32'd1);
    cmd(8'h02);
    check("csum_bad_run", {31'd0, core_select}, 32'd0);
    cmd(8'h04);
`endif

    // Asynchronous reset in the middle of a burst
    cmd(8'h55);
    send({8'h01, 8'd9, 16'h0800}, 0);
    d = $urandom;
    send(d, 0);
    @(negedge clk); rst_n = 0;
    #1; model_reset();
    check_all("rst_midburst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    send_write(16'h0900, 8'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_load_sequencer.md
# spi_load_sequencer

Packet-level controller for the SPI load path, clocked in the SPI clock domain. It sits behind the SPI word deserializer and parses its 32-bit word stream into commands. It sequences burst writes into instruction/data memory and owns the memory-ownership flag (`o_core_select`) that hands memory between the SPI loader and the RV32I core. A checksum trailer can be compiled in to gate core release on load integrity.

## Interface
Parameters:
- `ADDRESS_LENGTH`, 32: width of `o_wr_addr`; the 16-bit word address is zero-extended.
- `DATA_LENGTH`, 32: width of `i_word` and `o_wr_data`.

Ports:
- `w_SPI_Clk` in 1: SPI clock after CPOL/CPHA selection; the only clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_cs_n` in 1: SPI chip select, active-low; asynchronous packet abort when high.
- `i_word_vld` in 1: 1-cycle pulse, `i_word` complete.
- `i_word` in DATA_LENGTH: received word.
- `o_wr_en` out 1: 1-cycle memory write strobe.
- `o_wr_addr` out ADDRESS_LENGTH: word address of the write.
- `o_wr_data` out DATA_LENGTH: write data.
- `o_core_select` out 1: 1 = core owns memory; 0 = SPI loader owns memory.
- `o_busy` out 1: FSM not in IDLE.
- `o_err` out 1: sticky error flag.

## Operation
- Header word: `[31:24]` opcode, `[23:16]` LEN (burst = LEN+1 words, 1..256), `[15:0]` base word address.
- Opcodes:
  - 0x01 WRITE: burst write.
  - 0x02 RUN: set `o_core_select`=1, only if `o_err`=0; otherwise ignored.
  - 0x03 HALT: set `o_core_select`=0.
  - 0x04 CLR: clear `o_err`.
  - Any other opcode: set `o_err`; FSM stays IDLE.
- LEN and address fields are ignored for non-WRITE opcodes.
- WRITE is accepted only when `o_core_select`=0. If the core owns memory, set `o_err` and drop the header. Following words are then parsed as new headers.
- FSM states: IDLE -> (WRITE hdr) DATA -> (last data word) CSUM (macro only) -> IDLE. Single-word commands stay in IDLE.
- DATA: each `i_word_vld` issues one write at address base+k, k = 0..LEN. The address is 16-bit and wraps 0xFFFF -> 0x0000.
- The remaining-word counter is 8-bit, loaded with LEN and decremented per word; DATA exits when it reads 0 at a valid word.
- `i_word_vld` while `i_cs_n`=1 is ignored.
- `i_cs_n` high: state and counter are asynchronously cleared to IDLE/0. `o_core_select`, `o_err` and already-issued writes are unaffected. A truncated burst is silently dropped.
- Reset values: state IDLE, `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_core_select`=0, `o_busy`=0, `o_err`=0.

## Timing
- Write latency: `o_wr_en`/`o_wr_addr`/`o_wr_data` are registered and valid on the edge after the `i_word_vld` edge. They hold for exactly 1 cycle.
- Back-to-back `i_word_vld` (not physically possible at 32 bits/word, but must work) gives back-to-back writes.
- RUN/HALT/CLR take effect on the `o_core_select`/`o_err` outputs 1 cycle after the header's `i_word_vld`.
- `o_busy` rises 1 cycle after a WRITE header. It falls 1 cycle after the final word: the last data word, or the checksum word when the macro is enabled.
- Simultaneous `i_cs_n` rise and `i_word_vld`: the abort wins; no write is issued.
- Reset is asserted asynchronously and deasserted synchronously upstream. `i_rst_n` mid-burst: all outputs return to reset values immediately.

## Configuration
- `SPI_LOAD_CHECKSUM_EN` defined: after the last data word, one extra word is expected.
  - It must equal the XOR of the header and all data words.
  - Mismatch sets `o_err`, which blocks RUN until CLR. Writes already issued remain.
  - The checksum word does not produce a write.
- Not defined: no CSUM state; the FSM returns to IDLE right after the last data word and `o_err` is never set by loads.

## Structure
- Shared package: opcode constants (`OP_WRITE`, `OP_RUN`, `OP_HALT`, `OP_CLR`), state enum, header field bit positions.
- One sub-module: `spi_load_checksum`. It is a 32-bit XOR accumulator with clear/accumulate/compare, instantiated only under `SPI_LOAD_CHECKSUM_EN`.

## Test plan
- Reset, then WRITE 0x01_03_0010 + 4 words A,B,C,D -> writes at 0x10..0x13 with data A..D, one cycle after each vld; `o_busy` 1→0 after D.
- WRITE base 0xFFFE, LEN=2 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- RUN -> `o_core_select`=1; then WRITE -> `o_err`=1, no `o_wr_en`; HALT, CLR -> `o_core_select`=0, `o_err`=0.
- WRITE LEN=7, `i_cs_n` raised after 3 data words -> 3 writes only; next header is parsed correctly from IDLE.
- Opcode 0x55 -> `o_err`=1; RUN then ignored (`o_core_select` stays 0) until CLR.
- With `SPI_LOAD_CHECKSUM_EN`: correct XOR trailer -> `o_err`=0, RUN succeeds; trailer with one bit flipped -> `o_err`=1, RUN blocked.
